// File: rtl/gpio_cfg_regfile.sv
// ============================================================================
// gpio_cfg_regfile : GPIO-driven N-bank configuration store with shadow/commit
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpio_cfg_regfile #(
  parameter int                GPIO_W       = 32,
  parameter int                W_CLK_BIT    = 24,
  parameter int                ADDR_LSB     = 0,
  parameter int                ADDR_W       = 16,
  parameter int                DATA_LSB     = 16,
  parameter int                DATA_W       = 8,
  parameter int                N_BANKS      = 2,
  parameter int                BANK_DEPTH   = 256,
  parameter bit                SHADOW_EN    = 1'b1,
  parameter logic [ADDR_W-1:0] COMMIT_ADDR  = 16'hFFFF,
  parameter logic [ADDR_W-1:0] ERR_CLR_ADDR = 16'hFFFE,
  localparam int               BANK_W       = (N_BANKS > 1) ? $clog2(N_BANKS) : 1,
  localparam int               IDX_W        = (BANK_DEPTH > 1) ? $clog2(BANK_DEPTH) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [GPIO_W-1:0] gpio_in_i,
  input  logic [BANK_W-1:0] rd_bank_i,
  input  logic [IDX_W-1:0]  rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [N_BANKS-1:0] wr_strobe_o,
  output logic              commit_pulse_o,
  output logic              err_addr_o,
  output logic [15:0]       wr_count_o
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(BANK_DEPTH);
  localparam logic [ADDR_W-1:0] NBANK_A = ADDR_W'(N_BANKS);
  localparam logic [BANK_W:0]   NBANK_R = (BANK_W+1)'(N_BANKS);

  logic [2:0]               sync_q, sync_d;
  logic [DATA_W-1:0]        shadow_q [N_BANKS][BANK_DEPTH];
  logic [DATA_W-1:0]        active_q [N_BANKS][BANK_DEPTH];
  logic [DATA_W-1:0]        rd_data_q, rd_data_d;
  logic [N_BANKS-1:0]       wr_strobe_q, wr_strobe_d;
  logic                     commit_q, commit_d;
  logic                     err_addr_q, err_addr_d;
  logic [15:0]              wr_count_q, wr_count_d;

  logic                     wclk_event;
  logic [ADDR_W-1:0]        addr, bank_num, idx_full;
  logic [DATA_W-1:0]        wdata;
  logic [BANK_W-1:0]        bank_sel;
  logic [IDX_W-1:0]         idx;
  logic                     is_commit_addr, is_clr_addr, mapped;
  logic                     do_commit, do_clr, do_wr, do_err;
  logic                     unused_bits;

  // s1 = sync_q[0], s2 = sync_q[1], s3 = sync_q[2]; rising edge seen on s2 & ~s3
  assign sync_d     = {sync_q[1:0], gpio_in_i[W_CLK_BIT]};
  assign wclk_event = sync_q[1] & ~sync_q[2];

  assign addr     = gpio_in_i[ADDR_LSB +: ADDR_W];
  assign wdata    = gpio_in_i[DATA_LSB +: DATA_W];
  assign bank_num = addr / DEPTH_A;
  assign idx_full = addr % DEPTH_A;
  assign bank_sel = bank_num[BANK_W-1:0];
  assign idx      = idx_full[IDX_W-1:0];
  assign mapped   = (bank_num < NBANK_A);

  assign is_commit_addr = (addr == COMMIT_ADDR);
  assign is_clr_addr    = (addr == ERR_CLR_ADDR);

  // Commit address takes priority and is swallowed silently when shadowing is off
  assign do_commit = wclk_event & is_commit_addr & SHADOW_EN;
  assign do_clr    = wclk_event & ~is_commit_addr & is_clr_addr;
  assign do_wr     = wclk_event & ~is_commit_addr & ~is_clr_addr & mapped;
  assign do_err    = wclk_event & ~is_commit_addr & ~is_clr_addr & ~mapped;

  assign unused_bits = ^{gpio_in_i, bank_num, idx_full};

  always_comb begin
    err_addr_d  = err_addr_q;
    wr_count_d  = wr_count_q;
    wr_strobe_d = '0;
    commit_d    = do_commit;
    rd_data_d   = '0;
    if (do_clr) begin
      err_addr_d = 1'b0;
    end else if (do_err) begin
      err_addr_d = 1'b1;
    end
    if (do_wr) begin
      for (int b = 0; b < N_BANKS; b++) begin
        wr_strobe_d[b] = (bank_sel == BANK_W'(b));
      end
      if (wr_count_q != 16'hFFFF) begin
        wr_count_d = wr_count_q + 16'd1;
      end
    end
    if ({1'b0, rd_bank_i} < NBANK_R) begin
      rd_data_d = active_q[rd_bank_i][rd_addr_i];
    end
  end

  // Sync chain resets high so a write clock held through reset release is not an edge
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q      <= 3'b111;
      rd_data_q   <= '0;
      wr_strobe_q <= '0;
      commit_q    <= 1'b0;
      err_addr_q  <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      sync_q      <= sync_d;
      rd_data_q   <= rd_data_d;
      wr_strobe_q <= wr_strobe_d;
      commit_q    <= commit_d;
      err_addr_q  <= err_addr_d;
      wr_count_q  <= wr_count_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int b = 0; b < N_BANKS; b++) begin
        for (int i = 0; i < BANK_DEPTH; i++) begin
          shadow_q[b][i] <= '0;
          active_q[b][i] <= '0;
        end
      end
    end else if (do_commit) begin
      active_q <= shadow_q;
    end else if (do_wr) begin
      if (SHADOW_EN) begin
        shadow_q[bank_sel][idx] <= wdata;
      end else begin
        active_q[bank_sel][idx] <= wdata;
      end
    end
  end

  assign rd_data_o      = rd_data_q;
  assign wr_strobe_o    = wr_strobe_q;
  assign commit_pulse_o = commit_q;
  assign err_addr_o     = err_addr_q;
  assign wr_count_o     = wr_count_q;

endmodule

`default_nettype wire
